fx_dot_accum: RTL

//  Streaming fixed-point dot-product engine for the LSM regression stage. Accepts (a,b) operand

---
 rtl/qmc_fx_pkg.sv | 42 ++++
 rtl/fx_dot_accum_fxmul.sv | 69 ++++++
 rtl/fx_dot_accum.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/qmc_fx_pkg.sv
`default_nettype none
// ============================================================================
// Package    : qmc_fx_pkg
// Description: Shared Q-format constants, saturation helper and the
//              dot-product FSM state type.
// Revision   : 1.0 - initial release
// ============================================================================
package qmc_fx_pkg;

  localparam int Q_WIDTH = 32;
  localparam int Q_INT   = 16;
  localparam int Q_FRAC  = Q_WIDTH - Q_INT;
  localparam int Q_GUARD = 8;
  localparam int Q_ACC_W = Q_WIDTH + Q_GUARD;

  // 1.0 in the default Q format
  localparam logic [Q_WIDTH-1:0] c_one = Q_WIDTH'(1) << Q_FRAC;
  // Saturation limits of the default Q format
  localparam logic [Q_WIDTH-1:0] c_max = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] c_min = {1'b1, {(Q_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } dot_state_t;

  // Clamp a guard-extended accumulator to the result width. The value fits
  // when every bit from the result sign bit upward is a copy of the sign.
  function automatic logic [Q_WIDTH-1:0] sat_to_width(input logic [Q_ACC_W-1:0] v);
    logic [Q_GUARD:0] hi;
    hi = v[Q_ACC_W-1:Q_WIDTH-1];
    if ((hi == '0) || (hi == '1))
      sat_to_width = v[Q_WIDTH-1:0];
    else if (v[Q_ACC_W-1])
      sat_to_width = c_min;
    else
      sat_to_width = c_max;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_dot_accum_fxmul.sv
`default_nettype none
// ============================================================================
// Module     : fxMul
// Description: Pipelined signed fixed-point multiplier. The full product is
//              rounded half-up at the QFRAC boundary, shifted back into the
//              Q format and saturated to WIDTH bits. Result appears LATENCY
//              cycles after start. Requires QFRAC >= 1 and LATENCY >= 1.
// Revision   : 1.0 - initial release
// ============================================================================
module fxMul
  import qmc_fx_pkg::*;
#(
  parameter int WIDTH   = Q_WIDTH,
  parameter int QFRAC   = Q_FRAC,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] c_half = PW'(1) << (QFRAC - 1);

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_full;
  logic signed [PW-1:0] w_rnd;
  logic signed [PW-1:0] w_shr;
  logic [WIDTH:0]       w_hi;
  logic [WIDTH-1:0]     w_sat;

  logic [WIDTH-1:0]     r_pipe [LATENCY];
  logic [LATENCY-1:0]   r_vld;

  assign w_a    = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_b    = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_full = w_a * w_b;
  assign w_rnd  = w_full + c_half;
  assign w_shr  = w_rnd >>> QFRAC;
  assign w_hi   = w_shr[PW-1:WIDTH-1];
  assign w_sat  = ((w_hi == '0) || (w_hi == '1)) ? w_shr[WIDTH-1:0]
                : (w_shr[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}});

  // Capture the product on start, then push it down the delay stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      r_vld <= '0;
    end else begin
      r_vld[0] <= start;
      if (start) r_pipe[0] <= w_sat;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign product = r_pipe[LATENCY-1];
  assign done    = r_vld[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fx_dot_accum.sv
`default_nettype none
// ============================================================================
// Module     : fx_dot_accum
// Description: Streaming fixed-point dot product. Operand pairs are
//              multiplied in fxMul, products summed in a guard-bit
//              accumulator, and one saturated sum is emitted per vector.
// Revision   : 1.0 - initial release
// ============================================================================
module fx_dot_accum
  import qmc_fx_pkg::*;
#(
  parameter int WIDTH   = Q_WIDTH,
  parameter int QINT    = Q_INT,
  parameter int QFRAC   = WIDTH - QINT,
  parameter int LATENCY = 2,
  parameter int GUARD   = Q_GUARD,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNTW-1:0]  out_count,
  output logic             out_ovf
);

  localparam int ACCW = WIDTH + GUARD;

  dot_state_t         r_state;
  dot_state_t         w_state_next;
  logic [ACCW-1:0]    r_acc;
  logic [CNTW-1:0]    r_count;
  logic               r_ovf;
  logic [LATENCY-1:0] r_dvld;
  logic [LATENCY-1:0] r_dlast;

  logic [WIDTH-1:0]   w_prod;
  logic               w_accept;
  logic               w_handshake;
  logic               w_dvld;
  logic               w_dlast;
  logic [ACCW-1:0]    w_acc_sum;
  logic [GUARD:0]     w_sum_hi;
  logic               w_sum_fits;

  assign w_accept    = in_valid && in_ready;
  assign w_handshake = out_valid && out_ready;
  assign w_dvld      = r_dvld[LATENCY-1];
  assign w_dlast     = r_dlast[LATENCY-1];
  assign w_acc_sum   = r_acc + {{GUARD{w_prod[WIDTH-1]}}, w_prod};
  assign w_sum_hi    = w_acc_sum[ACCW-1:WIDTH-1];
  assign w_sum_fits  = (w_sum_hi == '0) || (w_sum_hi == '1);

  fxMul #(
    .WIDTH   (WIDTH),
    .QFRAC   (QFRAC),
    .LATENCY (LATENCY)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept),
    .a       (in_a),
    .b       (in_b),
    .product (w_prod),
    .done    ()
  );

  // Valid/last markers travel alongside the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvld  <= '0;
      r_dlast <= '0;
    end else begin
      r_dvld[0]  <= w_accept;
      r_dlast[0] <= w_accept && in_last;
      for (int i = 1; i < LATENCY; i++) begin
        r_dvld[i]  <= r_dvld[i-1];
        r_dlast[i] <= r_dlast[i-1];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs; in ACCUM in_ready is high, so a valid
  // last beat is always an accepted one
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_dvld && w_dlast) w_state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // Accumulate delayed products, count beats, track sticky range overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_handshake) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_dvld) begin
        r_acc <= w_acc_sum;
        if (!w_sum_fits) r_ovf <= 1'b1;
      end
      if (w_accept && (r_count != '1)) r_count <= r_count + CNTW'(1);
    end
  end

  // Final clamp: shared helper at the package widths, generic slice test otherwise
  generate
    if ((WIDTH == Q_WIDTH) && (GUARD == Q_GUARD)) begin : g_sat_pkg
      assign out_sum = sat_to_width(r_acc);
    end else begin : g_sat_gen
      logic [GUARD:0] w_hi;
      assign w_hi    = r_acc[ACCW-1:WIDTH-1];
      assign out_sum = ((w_hi == '0) || (w_hi == '1)) ? r_acc[WIDTH-1:0]
                     : (r_acc[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}});
    end
  endgenerate

  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule
`default_nettype wire
